pc_gen: RTL
===========

// Module: pc_gen
// PURPOSE
//  Registered next-PC generator for the fetch stage; successor to the combinational next-PC mux.
//  Holds the architectural fetch PC and offers it to IF with a valid/ready handshake.
//  Picks the next PC with fixed priority: CSR/trap redirect > EXE redirect > sequential/predicted.
//  Adds a boot cycle, a WFI-style halt state and an optional direct-mapped BTB.
// PARAMETERS
//  XLEN       64       PC width in bits
//  RESET_PC   64'h0    PC presented after the boot cycle
//  ILEN_BYTES 4        sequential increment; PC low log2(ILEN_BYTES) bits are always 0
//  BTB_DEPTH  16       BTB entries, power of 2 >= 2; used only with PC_GEN_BTB_EN
// PORTS
//  clk          in   1     clock, all state on rising edge
//  rstn         in   1     asynchronous active-low reset
//  pc           out  XLEN  current fetch PC
//  pc_valid     out  1     pc is offered to IF
//  if_ready     in   1     IF accepts pc this cycle (accept = pc_valid & if_ready)
//  pred_taken   out  1     BTB hit for pc this cycle; IF carries it down the pipe
//  trap_valid   in   1     CSR/trap redirect (mret, ecall, interrupt)
//  trap_pc      in   XLEN  trap target
//  redir_valid  in   1     EXE mispredict/jump redirect
//  redir_pc     in   XLEN  EXE-resolved target
//  halt_req     in   1     WFI: stop fetching after the current accept
//  upd_valid    in   1     EXE branch/jump resolved: BTB update
//  upd_pc       in   XLEN  PC of the resolved branch
//  upd_target   in   XLEN  resolved target
//  upd_taken    in   1     branch was taken
// BEHAVIOUR
//  Reset (async, rstn=0): pc=RESET_PC, pc_valid=0, pred_taken=0, state=BOOT, all BTB valid bits=0.
//  FSM states BOOT, RUN, HALT:
//   BOOT: exactly one cycle with pc_valid=0, then RUN with pc=RESET_PC, pc_valid=1.
//         A trap or redirect in BOOT loads pc and still moves to RUN.
//   RUN : pc_valid=1.
//         - trap_valid: pc<=trap_pc.
//         - else redir_valid: pc<=redir_pc.
//         - else accept: pc<=npc, where npc = pred_taken ? btb_target : pc+ILEN_BYTES.
//         - else: pc holds, so valid/pc stay stable while stalled.
//         Redirects are flushes: they may change pc while it is offered but not accepted.
//         halt_req with accept and no redirect: pc<=npc, go to HALT.
//         halt_req without accept waits in RUN.
//   HALT: pc_valid=0.
//         - trap_valid: pc<=trap_pc, go to RUN.
//         - redir_valid: pc<=redir_pc, stay in HALT.
//         - halt_req is ignored.
//  Same-cycle trap_valid and redir_valid: trap wins; redir is dropped.
//  Redirect targets are written with the low log2(ILEN_BYTES) bits forced to 0.
//  Arithmetic: pc+ILEN_BYTES is computed modulo 2^XLEN; all-ones-aligned PC wraps to 0 without a flag.
//  Latency: redirect seen at edge N gives the new pc with pc_valid=1 in cycle N+1 (one register stage).
//  BTB (direct-mapped):
//   - index = pc[IDX+1:2], IDX = log2(BTB_DEPTH); tag = pc[XLEN-1:IDX+2].
//   - Entry = {valid, tag, target}. pred_taken = valid & tag match (combinational read).
//   - upd_valid & upd_taken: write {1, tag, upd_target}, replacing any prior entry.
//   - upd_valid & !upd_taken & tag match: clear valid. Not taken and no match: no change.
//   - Update and lookup to the same index in one cycle: lookup sees the old entry.
//  Reset mid-operation: everything returns to reset values at once, including an in-flight HALT.
// CONFIGURATION
//  PC_GEN_BTB_EN defined: BTB instantiated as above.
//  PC_GEN_BTB_EN undefined: no BTB storage, pred_taken tied 0, npc=pc+ILEN_BYTES,
//   upd_* inputs ignored, BTB_DEPTH unused.
// STRUCTURE
//  pc_gen_pkg: state enum {BOOT,RUN,HALT}, btb_entry_t struct, ILEN_BYTES/IDX helper constants.
//  Sub-module pc_gen_btb: entry array, lookup and update; only instantiated under PC_GEN_BTB_EN.
// TESTING
//  1 Reset release, if_ready=1 -> cycle 1 pc_valid=0; then pc=0x0,0x4,0x8 on successive cycles.
//  2 if_ready=0 for 3 cycles at pc=0x10 -> pc stays 0x10, pc_valid=1; resumes at 0x14.
//  3 trap_valid (trap_pc=0x8000_0000) with redir_valid (redir_pc=0x200) in the same cycle
//    -> next pc=0x8000_0000.
//  4 halt_req accepted at pc=0x40 -> pc_valid=0, pc=0x44 held; redir_pc=0x100 -> still halted;
//    trap_pc=0x300 -> RUN with pc=0x300.
//  5 [BTB] upd pc=0x20 target=0x400 taken; later fetch 0x20 -> pred_taken=1, next pc=0x400;
//    upd not-taken for 0x20 -> next visit goes to 0x24.
//  6 [BTB] aliasing: upd 0x20 then 0x20+4*BTB_DEPTH (both taken) -> 0x20 misses, alias hits;
//    without the macro every test's pred_taken=0.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and helper constants for the fetch-stage PC generator.
//   state_t     : fetch FSM states (BOOT, RUN, HALT)
//   btb_entry_t : BTB read-out record {valid, tag, target}; fields are sized for
//                 the widest supported PC and zero-extended from narrower ones
//   helpers     : BTB index LSB and log2 helpers used to size index/alignment
// Used by pc_gen and pc_gen_btb (BTB only built when PC_GEN_BTB_EN is defined).
package pc_gen_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam int unsigned PC_MAX_W        = 64;
  localparam int unsigned DEF_ILEN_BYTES  = 4;
  // BTB index always starts at PC bit 2, independent of the fetch granule.
  localparam int unsigned BTB_IDX_LSB     = 2;

  typedef struct packed {
    logic                valid;
    logic [PC_MAX_W-1:0] tag;
    logic [PC_MAX_W-1:0] target;
  } btb_entry_t;

  function automatic int unsigned btb_idx_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned align_bits(input int unsigned ilen_bytes);
    return $clog2(ilen_bytes);
  endfunction

endpackage

// File: rtl/pc_gen_btb.sv
// pc_gen_btb: direct-mapped branch target buffer.
//   Lookup is a combinational read of the current fetch PC; an update in the
//   same cycle to the same index is only visible from the next cycle on.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset (clears valid bits)
//   i_lkp_pc             PC to look up
//   o_lkp_hit            entry valid and tag matches
//   o_lkp_target         stored target of the indexed entry
//   i_upd_valid          resolved branch/jump from EXE
//   i_upd_pc             PC of the resolved branch
//   i_upd_target         resolved target
//   i_upd_taken          branch was taken (write entry) / not taken (invalidate on match)
// DEPTH must be a power of two >= 2.
module pc_gen_btb
  import pc_gen_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] i_lkp_pc,
  output logic            o_lkp_hit,
  output logic [XLEN-1:0] o_lkp_target,
  input  logic            i_upd_valid,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic [XLEN-1:0] i_upd_target,
  input  logic            i_upd_taken
);

  localparam int unsigned IDX   = btb_idx_w(DEPTH);
  localparam int unsigned TAG_W = XLEN - IDX - BTB_IDX_LSB;

  // Valid bits are control state and get reset; tag/target are plain storage
  // that is only ever qualified by the valid bit.
  logic [DEPTH-1:0] r_valid;
  logic [TAG_W-1:0] r_tag    [DEPTH];
  logic [XLEN-1:0]  r_target [DEPTH];

  logic [IDX-1:0]   w_lkp_idx;
  logic [TAG_W-1:0] w_lkp_tag;
  logic [IDX-1:0]   w_upd_idx;
  logic [TAG_W-1:0] w_upd_tag;
  logic             w_upd_match;
  btb_entry_t       w_rd;

  assign w_lkp_idx = i_lkp_pc[IDX+BTB_IDX_LSB-1:BTB_IDX_LSB];
  assign w_lkp_tag = i_lkp_pc[XLEN-1:IDX+BTB_IDX_LSB];
  assign w_upd_idx = i_upd_pc[IDX+BTB_IDX_LSB-1:BTB_IDX_LSB];
  assign w_upd_tag = i_upd_pc[XLEN-1:IDX+BTB_IDX_LSB];

  always_comb begin
    w_rd        = '0;
    w_rd.valid  = r_valid[w_lkp_idx];
    w_rd.tag    = PC_MAX_W'(r_tag[w_lkp_idx]);
    w_rd.target = PC_MAX_W'(r_target[w_lkp_idx]);
  end

  assign o_lkp_hit    = w_rd.valid && (w_rd.tag == PC_MAX_W'(w_lkp_tag));
  assign o_lkp_target = w_rd.target[XLEN-1:0];

  // A not-taken resolution only evicts the entry it actually owns.
  assign w_upd_match = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= '0;
    end else if (i_upd_valid) begin
      if (i_upd_taken) begin
        r_valid[w_upd_idx] <= 1'b1;
      end else if (w_upd_match) begin
        r_valid[w_upd_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_upd_valid && i_upd_taken) begin
      r_tag[w_upd_idx]    <= w_upd_tag;
      r_target[w_upd_idx] <= i_upd_target;
    end
  end

  // Byte-offset bits below the index do not take part in lookup or update.
  logic w_unused_lsb;
  assign w_unused_lsb = ^{i_lkp_pc[BTB_IDX_LSB-1:0], i_upd_pc[BTB_IDX_LSB-1:0]};

endmodule

// File: rtl/pc_gen.sv
// pc_gen: registered next-PC generator for the fetch stage.
//   Holds the fetch PC and offers it to IF with a valid/ready handshake.
//   Next-PC priority: trap redirect > EXE redirect > predicted/sequential.
//   FSM: BOOT (one idle cycle after reset) -> RUN (offering) <-> HALT (WFI).
// Ports:
//   clk, rstn                clock, asynchronous active-low reset
//   pc, pc_valid             fetch PC and its valid towards IF
//   if_ready                 IF accepts pc (accept = pc_valid & if_ready)
//   pred_taken               BTB hit for the offered pc
//   trap_valid, trap_pc      CSR/trap redirect
//   redir_valid, redir_pc    EXE redirect
//   halt_req                 stop fetching after the current accept
//   upd_valid, upd_pc, upd_target, upd_taken   BTB update from EXE
// Configuration macro: PC_GEN_BTB_EN -- when defined a direct-mapped BTB of
//   BTB_DEPTH entries predicts taken branches; when undefined the next PC is
//   always pc+ILEN_BYTES and the upd_* inputs are ignored.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     ILEN_BYTES = DEF_ILEN_BYTES,
  parameter int unsigned     BTB_DEPTH  = 16
) (
  input  logic            clk,
  input  logic            rstn,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  input  logic            if_ready,
  output logic            pred_taken,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_pc,
  input  logic            halt_req,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken
);

  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(ILEN_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(PC_STEP - XLEN'(1));

  // Redirect targets must land on an instruction boundary.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return a & ALIGN_MASK;
  endfunction

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_npc;
  logic [XLEN-1:0] w_btb_target;
  logic            w_btb_hit;
  logic            w_run;
  logic            w_accept;

  assign w_run      = (r_state == ST_RUN);
  assign w_accept   = w_run && if_ready;
  assign pc         = r_pc;
  assign pc_valid   = w_run;
  // A prediction only means something for a PC that is actually offered.
  assign pred_taken = w_run && w_btb_hit;
  // Sequential increment wraps modulo 2^XLEN by construction.
  assign w_npc      = pred_taken ? align_pc(w_btb_target) : (r_pc + PC_STEP);

`ifdef PC_GEN_BTB_EN
  pc_gen_btb #(
    .XLEN  (XLEN),
    .DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk          (clk),
    .rstn         (rstn),
    .i_lkp_pc     (r_pc),
    .o_lkp_hit    (w_btb_hit),
    .o_lkp_target (w_btb_target),
    .i_upd_valid  (upd_valid),
    .i_upd_pc     (upd_pc),
    .i_upd_target (upd_target),
    .i_upd_taken  (upd_taken)
  );
`else
  assign w_btb_hit    = 1'b0;
  assign w_btb_target = '0;

  logic w_unused_upd;
  assign w_unused_upd = ^{upd_valid, upd_pc, upd_target, upd_taken, BTB_DEPTH[0]};
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    unique case (r_state)
      ST_BOOT: begin
        // The boot cycle always ends; an early redirect just replaces RESET_PC.
        w_state_nxt = ST_RUN;
        if (trap_valid) begin
          w_pc_nxt = align_pc(trap_pc);
        end else if (redir_valid) begin
          w_pc_nxt = align_pc(redir_pc);
        end
      end
      ST_RUN: begin
        // Redirects flush the offered PC whether or not IF took it; a halt
        // request is only honoured once the current PC is accepted.
        if (trap_valid) begin
          w_pc_nxt = align_pc(trap_pc);
        end else if (redir_valid) begin
          w_pc_nxt = align_pc(redir_pc);
        end else if (w_accept) begin
          w_pc_nxt = w_npc;
          if (halt_req) begin
            w_state_nxt = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        // Only a trap wakes fetch; an EXE redirect just retargets the halted PC.
        if (trap_valid) begin
          w_pc_nxt    = align_pc(trap_pc);
          w_state_nxt = ST_RUN;
        end else if (redir_valid) begin
          w_pc_nxt = align_pc(redir_pc);
        end
      end
      default: begin
        w_state_nxt = ST_BOOT;
        w_pc_nxt    = RESET_PC;
      end
    endcase
  end

  // ---- fetch PC register stage ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

endmodule
